mecobo_pin_ctrl: RTL and testbench

- Per-pin waveform controller for the Mecobo FPGA.
- Owns one 6-word configuration window in the EBI register space, starting at BASE_ADDR.
- Sequences a step counter that drives one output pin.
- One instance per pin. The top level ORs all rd_data buses and gives each instance BASE_ADDR = 0x32 + 6*pin.

---
 rtl/mecobo_pkg.sv | 28 ++
 rtl/mecobo_step_gen.sv | 73 +++++++
 rtl/mecobo_pin_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mecobo_pin_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mecobo_pkg.sv
// mecobo_pkg
//   Shared definitions for the Mecobo per-pin waveform controller:
//   register offsets inside one pin's configuration window, waveform
//   codes, window size and the controller FSM state type.
package mecobo_pkg;

    localparam int PIN_WORDS = 6;

    localparam logic [2:0] OFS_WAVE  = 3'd0;
    localparam logic [2:0] OFS_FREQ  = 3'd1;
    localparam logic [2:0] OFS_PHASE = 3'd2;
    localparam logic [2:0] OFS_TICKS = 3'd3;
    localparam logic [2:0] OFS_TICK  = 3'd4;
    localparam logic [2:0] OFS_LAST  = 3'd5;

    localparam logic [1:0] WAVE_IDLE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_SAW    = 2'd2;
    localparam logic [1:0] WAVE_TRI    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_RUN,
        ST_DONE
    } pin_state_e;

endpackage

// File: rtl/mecobo_step_gen.sv
// mecobo_step_gen
//   Holds the current waveform sample and advances it by one step per
//   step strobe, according to the selected waveform.
//   Ports:
//     clk_i      system clock
//     rst_ni     asynchronous active-low reset
//     wave_i     waveform code (square / sawtooth / triangle)
//     step_i     advance the sample by one step
//     restart_i  clear the sample and turn the triangle back to counting up
//     sample_o   current sample
module mecobo_step_gen
    import mecobo_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [1:0]  wave_i,
    input  logic        step_i,
    input  logic        restart_i,
    output logic [15:0] sample_o
);

    logic [15:0] sample_q, sample_d;
    logic        dirDown_q, dirDown_d;

    // Next-sample logic. The triangle turns around on the endpoint itself,
    // so 0xFFFF and 0x0000 each appear for exactly one step before the
    // direction reverses. A restart always wins over a step.
    always_comb begin
        sample_d  = sample_q;
        dirDown_d = dirDown_q;
        if (restart_i) begin
            sample_d  = 16'h0000;
            dirDown_d = 1'b0;
        end else if (step_i) begin
            case (wave_i)
                WAVE_SQUARE: sample_d = (sample_q == 16'h0000) ? 16'hFFFF : 16'h0000;
                WAVE_SAW:    sample_d = sample_q + 16'd1;
                WAVE_TRI: begin
                    if (!dirDown_q) begin
                        if (sample_q == 16'hFFFF) begin
                            sample_d  = 16'hFFFE;
                            dirDown_d = 1'b1;
                        end else begin
                            sample_d = sample_q + 16'd1;
                        end
                    end else begin
                        if (sample_q == 16'h0000) begin
                            sample_d  = 16'h0001;
                            dirDown_d = 1'b0;
                        end else begin
                            sample_d = sample_q - 16'd1;
                        end
                    end
                end
                default: sample_d = sample_q;
            endcase
        end
    end

    // Sample and triangle direction registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sample_q  <= 16'h0000;
            dirDown_q <= 1'b0;
        end else begin
            sample_q  <= sample_d;
            dirDown_q <= dirDown_d;
        end
    end

    assign sample_o = sample_q;

endmodule

// File: rtl/mecobo_pin_ctrl.sv
// mecobo_pin_ctrl
//   Per-pin waveform controller. Decodes a 6-word register window at
//   BASE_ADDR on the EBI bus and sequences a step counter that drives
//   one output pin.
//   Ports:
//     clk, reset            system clock, asynchronous active-low reset
//     bus_addr/wdata/wr/rd  EBI word address, write data and strobes
//     bus_rdata/rvalid      registered read data (0 when not addressed)
//     pin_out, pin_oe       pin drive value (sample MSB) and output enable
//     sample                current waveform sample
module mecobo_pin_ctrl
    import mecobo_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 21,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h32)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [15:0]       bus_wdata,
    input  logic              bus_wr,
    input  logic              bus_rd,
    output logic [15:0]       bus_rdata,
    output logic              bus_rvalid,
    output logic              pin_out,
    output logic              pin_oe,
    output logic [15:0]       sample
);

    logic [ADDR_W-1:0] winOffset;
    logic [2:0]        ofs;
    logic              inWindow, wrHit, rdHit, waveWr, startOk;
    logic              stepStrobe, restart;
    logic [15:0]       rdMux, tickInc;

    logic [15:0] wave_q, freq_q, phase_q, ticks_q;
    logic [15:0] curTick_q, curTick_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] rdata_q;
    logic        rvalid_q;
    pin_state_e  state_q, state_d;

    // Modular subtraction makes any address below BASE_ADDR wrap to a large
    // offset, so a single upper-bound compare selects the window.
    assign winOffset = bus_addr - BASE_ADDR;
    assign inWindow  = (winOffset < ADDR_W'(PIN_WORDS));
    assign ofs       = winOffset[2:0];
    assign wrHit     = bus_wr && inWindow;
    assign rdHit     = bus_rd && inWindow;
    assign waveWr    = wrHit && (ofs == OFS_WAVE);
    assign startOk   = (bus_wdata >= 16'd1) && (bus_wdata <= 16'd3) && (freq_q != 16'd0);
    assign tickInc   = (curTick_q == 16'hFFFF) ? curTick_q : curTick_q + 16'd1;

    // Writable configuration registers. Offsets 4 and 5 are read-only
    // status and silently drop writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wave_q  <= 16'h0000;
            freq_q  <= 16'h0000;
            phase_q <= 16'h0000;
            ticks_q <= 16'h0000;
        end else if (wrHit) begin
            case (ofs)
                OFS_WAVE:  wave_q  <= bus_wdata;
                OFS_FREQ:  freq_q  <= bus_wdata;
                OFS_PHASE: phase_q <= bus_wdata;
                OFS_TICKS: ticks_q <= bus_wdata;
                default:   ;
            endcase
        end
    end

    // Read mux over the current (pre-write) register values, so a read and a
    // write to the same word in one cycle return the old contents.
    always_comb begin
        rdMux = 16'h0000;
        case (ofs)
            OFS_WAVE:  rdMux = wave_q;
            OFS_FREQ:  rdMux = freq_q;
            OFS_PHASE: rdMux = phase_q;
            OFS_TICKS: rdMux = ticks_q;
            OFS_TICK:  rdMux = curTick_q;
            OFS_LAST:  rdMux = sample;
            default:   rdMux = 16'h0000;
        endcase
    end

    // Registered read port; data is forced to zero when this pin is not
    // addressed so the top level can OR all pins together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_q  <= 16'h0000;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdHit ? rdMux : 16'h0000;
            rvalid_q <= rdHit;
        end
    end

    // Sequencer next-state logic. DELAY counts the phase down and hands over
    // to RUN one step period before the first step; with zero phase RUN is
    // entered directly. RUN reloads from the live freq register at every step,
    // and a zero freq seen at that point parks the pin in IDLE without
    // stepping. A waveform write overrides everything else and suppresses
    // any step due in the same cycle.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        curTick_d  = curTick_q;
        stepStrobe = 1'b0;
        restart    = 1'b0;
        case (state_q)
            ST_DELAY: begin
                if (cnt_q <= 16'd1) begin
                    if (freq_q == 16'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                        cnt_d   = freq_q - 16'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            ST_RUN: begin
                if (cnt_q == 16'd0) begin
                    if (freq_q == 16'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        stepStrobe = 1'b1;
                        cnt_d      = freq_q - 16'd1;
                        curTick_d  = tickInc;
                        if ((ticks_q != 16'd0) && (tickInc >= ticks_q)) begin
                            state_d = ST_DONE;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: ;
        endcase
        if (waveWr) begin
            stepStrobe = 1'b0;
            if (startOk) begin
                restart   = 1'b1;
                curTick_d = 16'h0000;
                if (phase_q == 16'd0) begin
                    state_d = ST_RUN;
                    cnt_d   = freq_q - 16'd1;
                end else begin
                    state_d = ST_DELAY;
                    cnt_d   = phase_q;
                end
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    // Sequencer state, interval counter and completed-step counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 16'h0000;
            curTick_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            curTick_q <= curTick_d;
        end
    end

    mecobo_step_gen u_step_gen (
        .clk_i     (clk),
        .rst_ni    (reset),
        .wave_i    (wave_q[1:0]),
        .step_i    (stepStrobe),
        .restart_i (restart),
        .sample_o  (sample)
    );

    assign pin_out    = sample[15];
    assign pin_oe     = (state_q != ST_IDLE);
    assign bus_rdata  = rdata_q;
    assign bus_rvalid = rvalid_q;

endmodule

// File: tb/tb_mecobo_pin_ctrl.sv
// tb_mecobo_pin_ctrl
//   Directed bench for mecobo_pin_ctrl with an abstract timeline model:
//   each run is described by absolute cycle numbers of its next step
//   rather than by a countdown register.
module tb_mecobo_pin_ctrl;

    localparam logic [20:0] BASE = 21'h32;

    logic        clk;
    logic        reset;
    logic [20:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_wr;
    logic        bus_rd;
    logic [15:0] bus_rdata;
    logic        bus_rvalid;
    logic        pin_out;
    logic        pin_oe;
    logic [15:0] sample;

    int checks   = 0;
    int failures = 0;
    logic checkEn = 1'b0;

    // model state: 0 idle, 1 active (delaying or stepping), 2 done
    int          mState;
    longint      cyc;
    longint      mReloadAt;
    longint      mNextStep;
    int          triPos;
    logic [15:0] mWave, mFreq, mPhase, mTicks, mTick, mSample, mRdata;
    logic        mRvalid;

    mecobo_pin_ctrl #(
        .ADDR_W    (21),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wr     (bus_wr),
        .bus_rd     (bus_rd),
        .bus_rdata  (bus_rdata),
        .bus_rvalid (bus_rvalid),
        .pin_out    (pin_out),
        .pin_oe     (pin_oe),
        .sample     (sample)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%h expected 0x%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] modelReg(input int ofs);
        case (ofs)
            0: return mWave;
            1: return mFreq;
            2: return mPhase;
            3: return mTicks;
            4: return mTick;
            5: return mSample;
            default: return 16'h0000;
        endcase
    endfunction

    // Triangle expressed as a position on a 131070-step closed loop.
    task automatic modelStep();
        case (mWave)
            16'd1: mSample = (mSample == 16'h0000) ? 16'hFFFF : 16'h0000;
            16'd2: mSample = mSample + 16'd1;
            16'd3: begin
                triPos  = (triPos + 1) % 131070;
                mSample = (triPos <= 65535) ? 16'(triPos) : 16'(131070 - triPos);
            end
            default: ;
        endcase
        if (mTick != 16'hFFFF) mTick = mTick + 16'd1;
    endtask

    task automatic modelEdge();
        int          ofs;
        logic        inWin, waveWrite, rvNext, startOk;
        logic [15:0] rdNext;
        longint      c;
        c         = cyc;
        ofs       = int'(bus_addr) - int'(BASE);
        inWin     = (ofs >= 0) && (ofs <= 5);
        rvNext    = bus_rd && inWin;
        rdNext    = rvNext ? modelReg(ofs) : 16'h0000;
        waveWrite = bus_wr && inWin && (ofs == 0);
        if (mState == 1 && !waveWrite) begin
            if (c == mReloadAt) begin
                mReloadAt = -1;
                if (mFreq == 16'd0) mState = 0;
                else mNextStep = c + longint'(mFreq);
            end else if (c == mNextStep) begin
                if (mFreq == 16'd0) begin
                    mState = 0;
                end else begin
                    modelStep();
                    mNextStep = c + longint'(mFreq);
                    if (mTicks != 16'd0 && mTick >= mTicks) mState = 2;
                end
            end
        end
        if (bus_wr && inWin) begin
            case (ofs)
                0: begin
                    startOk = (bus_wdata >= 16'd1) && (bus_wdata <= 16'd3) && (mFreq != 16'd0);
                    mWave = bus_wdata;
                    if (startOk) begin
                        mState  = 1;
                        mTick   = 16'h0000;
                        mSample = 16'h0000;
                        triPos  = 0;
                        if (mPhase == 16'd0) begin
                            mReloadAt = -1;
                            mNextStep = c + longint'(mFreq);
                        end else begin
                            mReloadAt = c + longint'(mPhase);
                            mNextStep = -1;
                        end
                    end else begin
                        mState = 0;
                    end
                end
                1: mFreq  = bus_wdata;
                2: mPhase = bus_wdata;
                3: mTicks = bus_wdata;
                default: ;
            endcase
        end
        mRvalid = rvNext;
        mRdata  = rdNext;
        cyc     = cyc + 1;
    endtask

    // Reference model, advanced on every active edge from the bench inputs.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mState = 0; mReloadAt = -1; mNextStep = -1; triPos = 0;
            mWave = '0; mFreq = '0; mPhase = '0; mTicks = '0; mTick = '0; mSample = '0;
            mRdata = '0; mRvalid = 1'b0;
            cyc = 0;
        end else begin
            modelEdge();
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("sample", sample, mSample);
            checkOutput("pin_out", 16'(pin_out), 16'(mSample[15]));
            checkOutput("pin_oe", 16'(pin_oe), 16'(mState != 0));
            checkOutput("rvalid", 16'(bus_rvalid), 16'(mRvalid));
            checkOutput("rdata", bus_rdata, mRdata);
        end
    end

    // One bus cycle: inputs held over one active edge, then strobes dropped.
    task automatic applyStimulus(input logic wr, input logic rd, input logic [20:0] addr, input logic [15:0] data);
        bus_addr  = addr;
        bus_wdata = data;
        bus_wr    = wr;
        bus_rd    = rd;
        @(negedge clk); #1;
        bus_wr = 1'b0;
        bus_rd = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
        end
    endtask

    logic [15:0] triExp [8];
    int ffffSeen;

    initial begin
        reset = 1'b1; bus_addr = '0; bus_wdata = '0; bus_wr = 1'b0; bus_rd = 1'b0;
        #1 reset = 1'b0;
        checkEn = 1'b1;
        idle(3);
        reset = 1'b1;
        idle(1);

        // sawtooth at freq 2, then reset while running
        applyStimulus(1, 0, BASE + 21'd1, 16'd2);
        applyStimulus(1, 0, BASE + 21'd0, 16'd2);
        idle(7);
        checkOutput("preResetSample", sample, 16'h0003);
        reset = 1'b0;
        #1;
        checkOutput("asyncResetOe", 16'(pin_oe), 16'h0000);
        checkOutput("asyncResetSample", sample, 16'h0000);
        idle(2);
        reset = 1'b1;
        idle(1);
        checkOutput("rvalidBeforeRead", 16'(bus_rvalid), 16'h0000);
        applyStimulus(0, 1, BASE + 21'd4, 16'h0);
        checkOutput("tickAfterResetValid", 16'(bus_rvalid), 16'h0001);
        checkOutput("tickAfterReset", bus_rdata, 16'h0000);

        // square, freq 4, phase 0, unlimited
        applyStimulus(1, 0, BASE + 21'd1, 16'd4);
        applyStimulus(1, 0, BASE + 21'd2, 16'd0);
        applyStimulus(1, 0, BASE + 21'd3, 16'd0);
        applyStimulus(1, 0, BASE + 21'd0, 16'd1);
        idle(3);
        checkOutput("squareK3", 16'(pin_out), 16'h0000);
        idle(1);
        checkOutput("squareK4", 16'(pin_out), 16'h0001);
        idle(4);
        checkOutput("squareK8", 16'(pin_out), 16'h0000);
        idle(4);
        checkOutput("squareK12", 16'(pin_out), 16'h0001);
        applyStimulus(0, 1, BASE + 21'd4, 16'h0);
        checkOutput("squareTick", bus_rdata, 16'd3);

        // sawtooth, freq 1, phase 2, ticks 3
        applyStimulus(1, 0, BASE + 21'd1, 16'd1);
        applyStimulus(1, 0, BASE + 21'd2, 16'd2);
        applyStimulus(1, 0, BASE + 21'd3, 16'd3);
        applyStimulus(1, 0, BASE + 21'd0, 16'd2);
        checkOutput("sawK0", sample, 16'd0);
        idle(2);
        checkOutput("sawK2", sample, 16'd0);
        idle(1);
        checkOutput("sawK3", sample, 16'd1);
        idle(1);
        checkOutput("sawK4", sample, 16'd2);
        idle(1);
        checkOutput("sawK5", sample, 16'd3);
        idle(3);
        checkOutput("sawHeld", sample, 16'd3);
        checkOutput("sawDoneOe", 16'(pin_oe), 16'h0001);
        applyStimulus(0, 1, BASE + 21'd5, 16'h0);
        checkOutput("sawLastValue", bus_rdata, 16'h0003);

        // triangle around the top endpoint, sample preloaded to 0xFFFD
        applyStimulus(1, 0, BASE + 21'd2, 16'd0);
        applyStimulus(1, 0, BASE + 21'd3, 16'd0);
        applyStimulus(1, 0, BASE + 21'd0, 16'd3);
        force dut.u_step_gen.sample_q = 16'hFFFD;
        mSample = 16'hFFFD;
        triPos  = 65533;
        #1;
        release dut.u_step_gen.sample_q;
        triExp = '{16'hFFFE, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFF9};
        ffffSeen = 0;
        for (int i = 0; i < 8; i++) begin
            idle(1);
            checkOutput($sformatf("triStep%0d", i), sample, triExp[i]);
            if (sample == 16'hFFFF) ffffSeen++;
        end
        checkOutput("triTopOnce", 16'(ffffSeen), 16'd1);

        // square, then freq cleared mid-run
        applyStimulus(1, 0, BASE + 21'd1, 16'd4);
        applyStimulus(1, 0, BASE + 21'd0, 16'd1);
        idle(5);
        applyStimulus(1, 0, BASE + 21'd1, 16'd0);
        idle(1);
        checkOutput("freq0BeforeStepOe", 16'(pin_oe), 16'h0001);
        idle(1);
        checkOutput("freq0IdleOe", 16'(pin_oe), 16'h0000);
        checkOutput("freq0Held", sample, 16'hFFFF);
        applyStimulus(1, 0, BASE + 21'd0, 16'd7);
        applyStimulus(0, 1, BASE + 21'd0, 16'h0);
        checkOutput("wave7Read", bus_rdata, 16'd7);
        idle(4);
        checkOutput("wave7Idle", 16'(pin_oe), 16'h0000);

        // window boundaries, read-only writes, read/write collision
        applyStimulus(0, 1, BASE + 21'd6, 16'h0);
        checkOutput("aboveWinValid", 16'(bus_rvalid), 16'h0000);
        checkOutput("aboveWinData", bus_rdata, 16'h0000);
        applyStimulus(0, 1, BASE - 21'd1, 16'h0);
        checkOutput("belowWinValid", 16'(bus_rvalid), 16'h0000);
        checkOutput("belowWinData", bus_rdata, 16'h0000);
        applyStimulus(1, 0, BASE + 21'd4, 16'h1234);
        applyStimulus(0, 1, BASE + 21'd4, 16'h0);
        checkOutput("tickWriteIgnored", bus_rdata, 16'd1);
        applyStimulus(1, 1, BASE + 21'd1, 16'd9);
        checkOutput("rdWrSameOld", bus_rdata, 16'd0);
        applyStimulus(0, 1, BASE + 21'd1, 16'h0);
        checkOutput("rdWrSameNew", bus_rdata, 16'd9);
        idle(2);

        checkEn = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
